// File: rtl/tube_scan_display.sv
// Multiplexed N-digit seven-segment scanner with blank gap, PWM dimming,
// per-digit blink, frame-synchronous double buffering and pin polarity.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   digits       packed 4-bit digit codes, digit k at [4k+3:4k]
//   dp           decimal point per digit
//   blink        blink enable per digit
//   bright       brightness 0 (dimmest) .. 15 (full)
//   load         capture digits/dp/blink/bright into the pending buffer
//   en           one-hot digit enable
//   out          segments PGFEDCBA, bit 7 = dp
//   frame_start  one-cycle pulse at the start of digit 0's slot

module bcd_to_tube (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'h00;
    unique case (bcd)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = 7'h00;
    endcase
  end
endmodule

module tube_scan_display #(
  parameter int DIGITS         = 4,
  parameter int DIV_W          = 16,
  parameter int BLANK          = 16,
  parameter int BLINK_W        = 8,
  parameter int EN_ACTIVE_LOW  = 0,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   digits,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blink,
  input  logic [3:0]            bright,
  input  logic                  load,
  output logic [DIGITS-1:0]     en,
  output logic [7:0]            out,
  output logic                  frame_start
);

  localparam int IDW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [DIV_W-1:0]    cnt;
  logic [IDW-1:0]      id;
  logic [BLINK_W-1:0]  frame_cnt;

  logic                pend;
  logic [4*DIGITS-1:0] pend_dig;
  logic [DIGITS-1:0]   pend_dp;
  logic [DIGITS-1:0]   pend_bl;
  logic [3:0]          pend_br;

  logic [4*DIGITS-1:0] disp_dig;
  logic [DIGITS-1:0]   disp_dp;
  logic [DIGITS-1:0]   disp_bl;
  logic [3:0]          disp_br;

  logic [DIGITS-1:0]   en_q;
  logic [7:0]          out_q;
  logic                fs_q;

  logic                slot_end;
  logic                frame_end;
  logic [3:0]          cur_code;
  logic                cur_dp;
  logic                cur_bl;
  logic                lit;
  logic [DIGITS-1:0]   en_nx;
  logic [6:0]          seg;

  assign slot_end  = &cnt;
  assign frame_end = slot_end && (id == IDW'(DIGITS - 1));

  always_comb begin
    cur_code = 4'h0;
    cur_dp   = 1'b0;
    cur_bl   = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (id == IDW'(k)) begin
        cur_code = disp_dig[4*k +: 4];
        cur_dp   = disp_dp[k];
        cur_bl   = disp_bl[k];
      end
    end
  end

  // Dark during the blank gap, past the PWM threshold, or in the
  // off half of the blink period.
  assign lit = (cnt >= DIV_W'(BLANK))
            && (cnt[DIV_W-1 -: 4] <= disp_br)
            && !(cur_bl && frame_cnt[BLINK_W-1]);

  always_comb begin
    en_nx = '0;
    for (int k = 0; k < DIGITS; k++) begin
      en_nx[k] = lit && (id == IDW'(k));
    end
  end

  bcd_to_tube u_dec (
    .bcd (cur_code),
    .seg (seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      id        <= '0;
      frame_cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
      if (slot_end) begin
        id <= frame_end ? '0 : id + 1'b1;
      end
      if (frame_end) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  // A load coinciding with the boundary bypasses the pending buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend     <= 1'b0;
      pend_dig <= '0;
      pend_dp  <= '0;
      pend_bl  <= '0;
      pend_br  <= '0;
      disp_dig <= '0;
      disp_dp  <= '0;
      disp_bl  <= '0;
      disp_br  <= '0;
    end else begin
      if (load) begin
        pend_dig <= digits;
        pend_dp  <= dp;
        pend_bl  <= blink;
        pend_br  <= bright;
      end
      if (frame_end) begin
        pend <= 1'b0;
        if (load) begin
          disp_dig <= digits;
          disp_dp  <= dp;
          disp_bl  <= blink;
          disp_br  <= bright;
        end else if (pend) begin
          disp_dig <= pend_dig;
          disp_dp  <= pend_dp;
          disp_bl  <= pend_bl;
          disp_br  <= pend_br;
        end
      end else if (load) begin
        pend <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q  <= '0;
      out_q <= '0;
      fs_q  <= 1'b0;
    end else begin
      en_q  <= en_nx;
      out_q <= {cur_dp, seg};
      fs_q  <= (cnt == '0) && (id == '0);
    end
  end

  assign en          = (EN_ACTIVE_LOW != 0) ? ~en_q : en_q;
  assign out         = (SEG_ACTIVE_LOW != 0) ? ~out_q : out_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_tube_scan_display.sv
// Bench for tube_scan_display: time-based reference model plus
// directed sequences, on an active-high and an inverted instance.

module tb_tube_scan_display;

  localparam int SLOT  = 64;
  localparam int FRAME = 192;

  logic        clk;
  logic        rst_n;
  logic [11:0] digits;
  logic [2:0]  dp;
  logic [2:0]  blink;
  logic [3:0]  bright;
  logic        load;
  logic [2:0]  en_a;
  logic [7:0]  out_a;
  logic        fs_a;
  logic [2:0]  en_b;
  logic [7:0]  out_b;
  logic        fs_b;

  int checks = 0;
  int errors = 0;
  int k      = 0;

  typedef struct packed {
    logic [11:0] dg;
    logic [2:0]  dp;
    logic [2:0]  bl;
    logic [3:0]  br;
  } cont_t;

  typedef struct {
    int    s;
    cont_t c;
  } ld_t;

  ld_t lq[$];

  typedef struct {
    logic [3:0] code;
    logic       dpv;
    logic [7:0] exp;
  } vec_t;

  vec_t vt[16];

  tube_scan_display #(
    .DIGITS(3), .DIV_W(6), .BLANK(2), .BLINK_W(1),
    .EN_ACTIVE_LOW(0), .SEG_ACTIVE_LOW(0)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .digits(digits), .dp(dp),
    .blink(blink), .bright(bright), .load(load),
    .en(en_a), .out(out_a), .frame_start(fs_a)
  );

  tube_scan_display #(
    .DIGITS(3), .DIV_W(6), .BLANK(2), .BLINK_W(1),
    .EN_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .digits(digits), .dp(dp),
    .blink(blink), .bright(bright), .load(load),
    .en(en_b), .out(out_b), .frame_start(fs_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] segof(input logic [3:0] c);
    logic [6:0] t[16];
    t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return t[c];
  endfunction

  // Content shown in frame f = last load taken before that frame began.
  function automatic cont_t content_of(input int f);
    cont_t c;
    c = '0;
    foreach (lq[i]) begin
      if (lq[i].s < FRAME * f) c = lq[i].c;
    end
    return c;
  endfunction

  task automatic model(input int s, output logic [2:0] e,
                       output logic [7:0] o, output logic fs);
    int p, d, f;
    cont_t c;
    bit on;
    p = s % SLOT;
    d = (s / SLOT) % 3;
    f = s / FRAME;
    c = content_of(f);
    on = (p >= 2) && ((p / 4) <= int'(c.br)) && !(c.bl[d] && (f % 2 == 1));
    e = on ? 3'(1 << d) : 3'b000;
    o = {c.dp[d], segof(c.dg[4*d +: 4])};
    fs = (s % FRAME == 0);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (k=%0d)", nm, act, exp, k);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timing target missed (k=%0d)", nm, k);
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      k = 0;
      lq.delete();
    end else begin
      if (load) lq.push_back('{k, '{digits, dp, blink, bright}});
      k++;
    end
  end

  always @(negedge clk) begin
    logic [2:0] e, eb;
    logic [7:0] o, ob;
    logic       f;
    if (rst_n && k >= 1) begin
      model(k - 1, e, o, f);
      eb = ~e;
      ob = ~o;
      chk("mon_en_a", 32'(en_a), 32'(e));
      chk("mon_out_a", 32'(out_a), 32'(o));
      chk("mon_fs_a", 32'(fs_a), 32'(f));
      chk("mon_en_b", 32'(en_b), 32'(eb));
      chk("mon_out_b", 32'(out_b), 32'(ob));
      chk("mon_fs_b", 32'(fs_b), 32'(f));
    end
  end

  task automatic load_at(input int s, input logic [11:0] dg,
                         input logic [2:0] dpv, input logic [2:0] bl,
                         input logic [3:0] br);
    int g;
    g = 0;
    while (k < s && g < 50000) begin
      @(negedge clk);
      g++;
    end
    if (k != s) fail_now("load_at");
    digits = dg;
    dp     = dpv;
    blink  = bl;
    bright = br;
    load   = 1'b1;
    @(negedge clk);
    load   = 1'b0;
  endtask

  task automatic check_at(input int s, input logic [2:0] e,
                          input logic [7:0] o, input string nm);
    int g;
    logic [2:0] eb;
    logic [7:0] ob;
    g = 0;
    while (k < s + 1 && g < 50000) begin
      @(negedge clk);
      g++;
    end
    if (k != s + 1) begin
      fail_now(nm);
    end else begin
      eb = ~e;
      ob = ~o;
      chk({nm, "_en"}, 32'(en_a), 32'(e));
      chk({nm, "_out"}, 32'(out_a), 32'(o));
      chk({nm, "_en_inv"}, 32'(en_b), 32'(eb));
      chk({nm, "_out_inv"}, 32'(out_b), 32'(ob));
    end
  endtask

  initial begin
    int s0;
    logic [7:0] e8;
    for (int i = 0; i < 16; i++) begin
      vt[i].code = 4'(i);
      vt[i].dpv  = 1'(i % 2);
      e8 = {1'(i % 2), segof(4'(i))};
      vt[i].exp  = e8;
    end

    rst_n  = 1'b0;
    digits = '0;
    dp     = '0;
    blink  = '0;
    bright = '0;
    load   = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_en_a", 32'(en_a), 32'h0);
    chk("rst_out_a", 32'(out_a), 32'h0);
    chk("rst_fs_a", 32'(fs_a), 32'h0);
    chk("rst_en_b", 32'(en_b), 32'h7);
    chk("rst_out_b", 32'(out_b), 32'hFF);
    @(negedge clk);
    rst_n = 1'b1;

    load_at(5, 12'h321, 3'b100, 3'b000, 4'd15);
    check_at(192, 3'b000, 8'h06, "f1_start");
    chk("f1_fs", 32'(fs_a), 32'h1);
    check_at(202, 3'b001, 8'h06, "f1_d0");
    check_at(257, 3'b000, 8'h5B, "f1_d1_blank");
    check_at(266, 3'b010, 8'h5B, "f1_d1");
    check_at(330, 3'b100, 8'hCF, "f1_d2");
    check_at(384, 3'b000, 8'h06, "f2_start");
    chk("f2_fs", 32'(fs_a), 32'h1);

    load_at(458, 12'h654, 3'b000, 3'b000, 4'd15);
    check_at(522, 3'b100, 8'hCF, "midload_old");
    check_at(714, 3'b100, 8'h7D, "midload_new");
    load_at(767, 12'h987, 3'b000, 3'b000, 4'd15);
    check_at(778, 3'b001, 8'h07, "coincident");

    load_at(800, 12'h987, 3'b000, 3'b000, 4'd0);
    check_at(961, 3'b000, 8'h07, "br0_c1");
    check_at(962, 3'b001, 8'h07, "br0_c2");
    check_at(963, 3'b001, 8'h07, "br0_c3");
    check_at(964, 3'b000, 8'h07, "br0_c4");
    load_at(1000, 12'h987, 3'b000, 3'b000, 4'd7);
    check_at(1183, 3'b001, 8'h07, "br7_c31");
    check_at(1184, 3'b000, 8'h07, "br7_c32");

    load_at(1200, 12'h987, 3'b000, 3'b010, 4'd15);
    check_at(1354, 3'b001, 8'h07, "blink_odd_d0");
    check_at(1418, 3'b000, 8'h7F, "blink_odd_d1");
    check_at(1482, 3'b100, 8'h6F, "blink_odd_d2");
    check_at(1610, 3'b010, 8'h7F, "blink_even_d1");

    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(10, 300)) @(negedge clk);
      digits = 12'($urandom);
      dp     = 3'($urandom);
      blink  = 3'($urandom);
      bright = 4'($urandom);
      load   = 1'b1;
      @(negedge clk);
      load   = 1'b0;
    end

    for (int i = 0; i < 16; i++) begin
      s0 = k;
      load_at(s0, {3{vt[i].code}}, {3{vt[i].dpv}}, 3'b000, 4'd15);
      check_at(FRAME * (s0 / FRAME + 1) + 10, 3'b001, vt[i].exp, "dec_tbl");
    end

    load_at(FRAME * (k / FRAME + 1) + 20, 12'h888, 3'b111, 3'b000, 4'd15);
    repeat (10) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_en_a", 32'(en_a), 32'h0);
    chk("async_out_a", 32'(out_a), 32'h0);
    chk("async_en_b", 32'(en_b), 32'h7);
    chk("async_out_b", 32'(out_b), 32'hFF);
    chk("async_fs_b", 32'(fs_b), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_at(2, 3'b001, 8'h3F, "post_rst_c2");
    check_at(4, 3'b000, 8'h3F, "post_rst_c4");
    check_at(194, 3'b001, 8'h3F, "pend_lost");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
